// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle sequencing controller (FETCH/DECODE/EXEC/MEM/WB).
// One instruction in flight; outputs are Moore decodes of the state register,
// gated by stall/decode inputs only where a transition depends on them.
// Optional feature macro: PERF_CNT_EN builds the retired-instruction and
// active-cycle counters; without it both counter outputs are tied to 0.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             regWriteEn,
  input  logic             halt,
  input  logic             decErr,
  input  logic             fetchStall,
  input  logic             memStall,
  output logic             irWriteEn,
  output logic             fetchEn,
  output logic             memEn,
  output logic             memWr,
  output logic             rfWriteEn,
  output logic             pcWriteEn,
  output logic             haltOut,
  output logic             errOut,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instrCount,
  output logic [CNT_W-1:0] cycleCount
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout_hit;

  // Last permitted stall cycle in MEM; MEM_TIMEOUT of 0 disables the check.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_LAST);

  // Next-state and MEM wait counter; the counter only lives inside MEM.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (!fetchStall) state_d = S_DECODE;
      S_DECODE: begin
        if (decErr)    state_d = S_ERROR;
        else if (halt) state_d = S_HALTED;
        else           state_d = S_EXEC;
      end
      S_EXEC: begin
        if (memRead || memWrite) state_d = S_MEM;
        else if (regWriteEn)     state_d = S_WB;
        else                     state_d = S_FETCH;
      end
      S_MEM: begin
        if (memStall) begin
          wait_d = wait_q + CNT_W'(1);
          if (timeout_hit) state_d = S_ERROR;
        end else if (memRead && regWriteEn) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = state_q;  // HALTED / ERROR are sticky until rst
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Output decode; reset forces IDLE asynchronously so every output drops at once.
  always_comb begin
    irWriteEn = 1'b0;
    fetchEn   = 1'b0;
    memEn     = 1'b0;
    memWr     = 1'b0;
    rfWriteEn = 1'b0;
    pcWriteEn = 1'b0;
    haltOut   = 1'b0;
    errOut    = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetchEn   = 1'b1;
        irWriteEn = !fetchStall;
      end
      S_EXEC:   pcWriteEn = !(memRead || memWrite) && !regWriteEn;
      S_MEM: begin
        memEn     = 1'b1;
        memWr     = memWrite;
        pcWriteEn = !memStall && !(memRead && regWriteEn);
      end
      S_WB: begin
        rfWriteEn = 1'b1;
        pcWriteEn = 1'b1;
      end
      S_HALTED: haltOut = 1'b1;
      S_ERROR:  errOut  = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] instr_q, cyc_q;

  // Retire count follows pcWriteEn; cycle count covers every active state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      cyc_q   <= '0;
    end else begin
      if (pcWriteEn) instr_q <= instr_q + CNT_W'(1);
      if (state_q != S_IDLE && state_q != S_HALTED && state_q != S_ERROR)
        cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign instrCount = instr_q;
  assign cycleCount = cyc_q;
`else
  assign instrCount = '0;
  assign cycleCount = '0;
`endif

endmodule
